// File: rtl/qea_host_sequencer.sv
// Host-side sequencer for the quantum emulation accelerator.
// Loads gate context, seeds the basis state, runs the emulator and streams the state vector back.
module qea_host_sequencer #(
  parameter int PE_NUM                  = 4,
  parameter int PE_NUM_WIDTH            = 2,
  parameter int DATA_WIDTH              = 32,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int RD_LATENCY              = 1,
  parameter int CYC_CNT_WIDTH           = 32,
  parameter int TIMEOUT_CYCLES          = 2**20
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     i_ins_num,
  input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] i_init_idx,
  input  logic                                   s_ctx_valid,
  output logic                                   s_ctx_ready,
  input  logic [2*DATA_WIDTH-1:0]                s_ctx_data,
  output logic                                   m_state_valid,
  input  logic                                   m_state_ready,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]         m_state_data,
  output logic                                   m_state_last,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_timeout,
  output logic [CYC_CNT_WIDTH-1:0]               o_cycle_count,
  output logic                                   o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]              o_qea_qbit_num,
  output logic                                   o_qea_ctx_en,
  output logic                                   o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     o_qea_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]                o_qea_ctx_data,
  output logic [PE_NUM-1:0]                      o_qea_state_ena,
  output logic [PE_NUM-1:0]                      o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]            o_qea_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]         o_qea_state_dina,
  input  logic                                   i_qea_complete,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]         i_qea_state_dout
);

  localparam int CTX_W     = 2*DATA_WIDTH;
  localparam int ROW_W     = PE_NUM*CTX_W;
  localparam int IDX_W     = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int WAIT_LAST = (RD_LATENCY > 0) ? RD_LATENCY-1 : 0;
  localparam logic [DATA_WIDTH-1:0]    FIX_ONE     = DATA_WIDTH'(64'd1 << NUM_FRAC_BIT);
  localparam logic [CYC_CNT_WIDTH-1:0] TIMEOUT_VAL = CYC_CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
  } state_t;

  state_t state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]          qbit_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q, ctx_cnt_q;
  logic [IDX_W-1:0]                   idx_q, go_mask;
  logic [STATE_ADDR_WIDTH-1:0]        row_q, last_row, tgt_row;
  logic [PE_NUM_WIDTH-1:0]            tgt_lane;
  logic [7:0]                         wait_q;
  logic [CYC_CNT_WIDTH-1:0]           cyc_q, cyc_inc;
  logic                               timeout_q, hit_timeout;
  logic [ROW_W-1:0]                   rd_data_q, init_row;

  // Index wrap mask for the incoming qubit count, applied once at latch time.
  always_comb begin
    go_mask = '1;
    if (int'(i_qbit_num) < IDX_W)
      go_mask = IDX_W'((64'd1 << i_qbit_num) - 64'd1);
  end

  always_comb begin
    last_row = '1;
    if (int'(qbit_q) <= PE_NUM_WIDTH)
      last_row = '0;
    else if (int'(qbit_q) - PE_NUM_WIDTH < STATE_ADDR_WIDTH)
      last_row = STATE_ADDR_WIDTH'((64'd1 << (int'(qbit_q) - PE_NUM_WIDTH)) - 64'd1);
  end

  // Lane order is reversed: basis index 0 lands in the most significant lane.
  assign tgt_row  = idx_q[IDX_W-1:PE_NUM_WIDTH];
  assign tgt_lane = PE_NUM_WIDTH'(PE_NUM - 1) - idx_q[PE_NUM_WIDTH-1:0];

  always_comb begin
    init_row = '0;
    for (int j = 0; j < PE_NUM; j++)
      if (row_q == tgt_row && tgt_lane == PE_NUM_WIDTH'(j))
        init_row[j*CTX_W + DATA_WIDTH +: DATA_WIDTH] = FIX_ONE;
  end

  assign cyc_inc     = cyc_q + CYC_CNT_WIDTH'(1);
  assign hit_timeout = (TIMEOUT_CYCLES != 0) && !i_qea_complete && (cyc_inc == TIMEOUT_VAL);

  always_comb begin
    state_d           = state_q;
    s_ctx_ready       = 1'b0;
    m_state_valid     = 1'b0;
    m_state_last      = 1'b0;
    o_done            = 1'b0;
    o_qea_start       = 1'b0;
    o_qea_ctx_en      = 1'b0;
    o_qea_ctx_wea     = 1'b0;
    o_qea_ctx_addr    = '0;
    o_qea_ctx_data    = '0;
    o_qea_state_ena   = '0;
    o_qea_state_wea   = '0;
    o_qea_state_addra = '0;
    o_qea_state_dina  = '0;
    case (state_q)
      IDLE: if (i_go) state_d = (i_ins_num == '0) ? INIT_STATE : LOAD_CTX;
      LOAD_CTX: begin
        s_ctx_ready = 1'b1;
        if (s_ctx_valid) begin
          o_qea_ctx_en   = 1'b1;
          o_qea_ctx_wea  = 1'b1;
          o_qea_ctx_addr = ctx_cnt_q;
          o_qea_ctx_data = s_ctx_data;
          if (ctx_cnt_q == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)) state_d = INIT_STATE;
        end
      end
      INIT_STATE: begin
        o_qea_state_ena   = '1;
        o_qea_state_wea   = '1;
        o_qea_state_addra = row_q;
        o_qea_state_dina  = init_row;
        if (row_q == last_row) state_d = START;
      end
      START: begin
        o_qea_start = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (i_qea_complete)   state_d = RD_ISSUE;
        else if (hit_timeout) state_d = DONE;
      end
      RD_ISSUE: begin
        o_qea_state_ena   = '1;
        o_qea_state_addra = row_q;
        state_d           = RD_WAIT;
      end
      RD_WAIT: if (wait_q == 8'(WAIT_LAST)) state_d = RD_HOLD;
      RD_HOLD: begin
        m_state_valid = 1'b1;
        m_state_last  = (row_q == last_row);
        if (m_state_ready) state_d = m_state_last ? DONE : RD_ISSUE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers advance alongside the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      qbit_q    <= '0;
      ins_q     <= '0;
      idx_q     <= '0;
      ctx_cnt_q <= '0;
      row_q     <= '0;
      wait_q    <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (i_go) begin
          qbit_q    <= i_qbit_num;
          ins_q     <= i_ins_num;
          idx_q     <= i_init_idx & go_mask;
          ctx_cnt_q <= '0;
          row_q     <= '0;
          timeout_q <= 1'b0;
        end
        LOAD_CTX: if (s_ctx_valid) ctx_cnt_q <= ctx_cnt_q + GATE_CONTEXT_ADDR_WIDTH'(1);
        INIT_STATE: row_q <= (row_q == last_row) ? '0 : row_q + STATE_ADDR_WIDTH'(1);
        START: cyc_q <= '0;
        RUN: begin
          cyc_q <= cyc_inc;
          if (hit_timeout) timeout_q <= 1'b1;
        end
        RD_ISSUE: wait_q <= '0;
        RD_WAIT: begin
          wait_q <= wait_q + 8'd1;
          if (wait_q == 8'(WAIT_LAST)) rd_data_q <= i_qea_state_dout;
        end
        RD_HOLD: if (m_state_ready && row_q != last_row) row_q <= row_q + STATE_ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  assign o_busy         = (state_q != IDLE);
  assign o_qea_qbit_num = o_busy ? qbit_q : '0;
  assign o_timeout      = timeout_q;
  assign o_cycle_count  = cyc_q;
  assign m_state_data   = rd_data_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with a behavioural state RAM and emulator stand-in.
module tb_qea_host_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_go;
  logic [5:0]    i_qbit_num;
  logic [15:0]   i_ins_num;
  logic [17:0]   i_init_idx;
  logic          s_ctx_valid, s_ctx_ready;
  logic [63:0]   s_ctx_data;
  logic          m_state_valid, m_state_ready, m_state_last;
  logic [255:0]  m_state_data;
  logic          o_busy, o_done, o_timeout;
  logic [31:0]   o_cycle_count;
  logic          o_qea_start;
  logic [5:0]    o_qea_qbit_num;
  logic          o_qea_ctx_en, o_qea_ctx_wea;
  logic [15:0]   o_qea_ctx_addr;
  logic [63:0]   o_qea_ctx_data;
  logic [3:0]    o_qea_state_ena, o_qea_state_wea;
  logic [15:0]   o_qea_state_addra;
  logic [255:0]  o_qea_state_dina;
  logic          i_qea_complete;
  logic [255:0]  ram_dout;

  qea_host_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num), .i_init_idx(i_init_idx),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
    .m_state_valid(m_state_valid), .m_state_ready(m_state_ready),
    .m_state_data(m_state_data), .m_state_last(m_state_last),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_cycle_count(o_cycle_count),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
    .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
    .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
    .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(ram_dout)
  );

  int vec_count  = 0;
  int miss_count = 0;

  function automatic logic [255:0] row_pat(input int r);
    logic [255:0] v;
    for (int j = 0; j < 4; j++) v[j*64 +: 64] = {32'(r*16 + j), ~32'(r*16 + j)};
    return v;
  endfunction

  function automatic logic [63:0] ctx_pat(input int i);
    return {32'(i) ^ 32'h1234_5678, 32'hC0DE_0000 + 32'(i)};
  endfunction

  function automatic logic [255:0] init_word(input int lane);
    logic [255:0] v;
    v = '0;
    v[lane*64 + 32 +: 32] = 32'h4000_0000;
    return v;
  endfunction

  // State RAM with one-cycle registered read; emu_fill mimics the emulator rewriting state.
  logic [255:0] state_mem [0:255];
  logic emu_fill = 1'b0;
  int state_wr_count = 0;
  int rd_issue_count = 0;
  int beat_count = 0;

  always @(posedge clk) begin
    if (emu_fill)
      for (int r = 0; r < 256; r++) state_mem[r] <= row_pat(r);
    if (o_qea_state_ena != 4'd0) begin
      for (int j = 0; j < 4; j++)
        if (o_qea_state_wea[j])
          state_mem[o_qea_state_addra[7:0]][j*64 +: 64] <= o_qea_state_dina[j*64 +: 64];
      if (o_qea_state_wea != 4'd0) state_wr_count <= state_wr_count + 1;
      else                         rd_issue_count <= rd_issue_count + 1;
      ram_dout <= state_mem[o_qea_state_addra[7:0]];
    end
    if (m_state_valid && m_state_ready) beat_count <= beat_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int qbit, input int ins, input int idx);
    i_qbit_num = 6'(qbit);
    i_ins_num  = 16'(ins);
    i_init_idx = 18'(idx);
    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    i_qbit_num = '0;
    i_ins_num  = '0;
    i_init_idx = '0;
  endtask

  task automatic loadContext(input int n);
    int sent = 0;
    int errs = 0;
    int guard = 0;
    s_ctx_valid = 1'b1;
    while (sent < n && guard < 5000) begin
      s_ctx_data = ctx_pat(sent);
      @(negedge clk);
      if (s_ctx_ready) begin
        if (!(o_qea_ctx_en && o_qea_ctx_wea) || o_qea_ctx_addr != 16'(sent) || o_qea_ctx_data !== ctx_pat(sent))
          errs++;
        sent++;
      end else if (o_qea_ctx_en || o_qea_ctx_wea) errs++;
      @(posedge clk); #1;
      guard++;
    end
    s_ctx_valid = 1'b0;
    checkOutput("ctx_words", 256'(sent), 256'(n));
    checkOutput("ctx_addr_data", 256'(errs), 256'(0));
  endtask

  task automatic waitStart();
    int g = 0;
    @(negedge clk);
    while (!o_qea_start && g < 3000) begin
      @(negedge clk);
      g++;
    end
    checkOutput("start_seen", 256'(o_qea_start), 256'(1));
  endtask

  task automatic checkInit(input string pfx, input int rows, input int trow, input int lane, input int wr0);
    int errs = 0;
    for (int r = 0; r < rows; r++)
      if (r != trow && state_mem[r] !== 256'(0)) errs++;
    checkOutput({pfx, "_init_rows"}, 256'(state_wr_count - wr0), 256'(rows));
    checkOutput({pfx, "_init_target"}, state_mem[trow], init_word(lane));
    checkOutput({pfx, "_init_zero"}, 256'(errs), 256'(0));
  endtask

  task automatic runToComplete(input int d);
    @(negedge clk);
    checkOutput("start_one_cycle", 256'(o_qea_start), 256'(0));
    emu_fill = 1'b1;
    @(posedge clk); #1;
    emu_fill = 1'b0;
    repeat (d-1) @(negedge clk);
    i_qea_complete = 1'b1;
    @(posedge clk); #1;
    i_qea_complete = 1'b0;
    @(negedge clk);
    checkOutput("cycle_count", 256'(o_cycle_count), 256'(d));
  endtask

  task automatic readBack(input int rows, input int stall_beat, input int d);
    int b0 = beat_count;
    int data_errs = 0;
    int last_errs = 0;
    int lost = 0;
    for (int b = 0; b < rows; b++) begin
      int g = 0;
      while (!m_state_valid && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!m_state_valid) begin
        lost++;
        break;
      end
      if (m_state_data !== row_pat(b)) data_errs++;
      if (m_state_last !== (b == rows-1)) last_errs++;
      if (b == stall_beat) begin
        logic [255:0] data0 = m_state_data;
        int rd0 = rd_issue_count;
        int stall_errs = 0;
        repeat (10) begin
          @(negedge clk);
          if (!m_state_valid || m_state_data !== data0 || o_qea_state_ena != 4'd0) stall_errs++;
        end
        checkOutput("stall_stable", 256'(stall_errs), 256'(0));
        checkOutput("stall_no_read", 256'(rd_issue_count - rd0), 256'(0));
      end
      m_state_ready = 1'b1;
      @(posedge clk); #1;
      m_state_ready = 1'b0;
    end
    checkOutput("rb_valid_lost", 256'(lost), 256'(0));
    checkOutput("rb_data", 256'(data_errs), 256'(0));
    checkOutput("rb_last", 256'(last_errs), 256'(0));
    checkOutput("rb_beats", 256'(beat_count - b0), 256'(rows));
    @(negedge clk);
    checkOutput("done_pulse", 256'({o_done, o_busy}), 256'(2'b11));
    @(negedge clk);
    checkOutput("done_cleared", 256'({o_done, o_busy}), 256'(2'b00));
    checkOutput("count_frozen", 256'(o_cycle_count), 256'(d));
  endtask

  initial begin
    int wr0, b0, g;
    i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_init_idx = '0;
    s_ctx_valid = 1'b0; s_ctx_data = '0; m_state_ready = 1'b0; i_qea_complete = 1'b0;
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_flags", 256'({o_busy, o_done, o_timeout, m_state_valid, s_ctx_ready, o_qea_start, o_qea_ctx_en}), 256'(0));
    checkOutput("reset_count", 256'(o_cycle_count), 256'(0));
    checkOutput("reset_ram_strobes", 256'({o_qea_state_ena, o_qea_state_wea}), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] full sequence qbit 8, 209 ctx words");
    wr0 = state_wr_count;
    applyStimulus(8, 209, 0);
    checkOutput("busy_after_go", 256'(o_busy), 256'(1));
    checkOutput("qbit_latched", 256'(o_qea_qbit_num), 256'(8));
    loadContext(209);
    waitStart();
    checkInit("A", 64, 0, 3, wr0);
    runToComplete(37);
    readBack(64, 2, 37);

    $display("[TB] timeout with qbit 2, index wrap 6 -> 2");
    wr0 = state_wr_count;
    applyStimulus(2, 0, 6);
    waitStart();
    checkInit("T", 1, 0, 1, wr0);
    m_state_ready = 1'b1;
    b0 = beat_count;
    repeat (50) @(negedge clk);
    i_go = 1'b1; i_qbit_num = 6'd7;
    @(negedge clk);
    i_go = 1'b0; i_qbit_num = '0;
    repeat (49) @(negedge clk);
    checkOutput("go_ignored_qbit", 256'(o_qea_qbit_num), 256'(2));
    checkOutput("pre_timeout", 256'({o_timeout, o_done}), 256'(0));
    checkOutput("pre_timeout_count", 256'(o_cycle_count), 256'(99));
    @(negedge clk);
    checkOutput("timeout_done", 256'({o_timeout, o_done}), 256'(2'b11));
    checkOutput("timeout_count", 256'(o_cycle_count), 256'(100));
    @(negedge clk);
    checkOutput("timeout_sticky", 256'({o_timeout, o_done, o_busy}), 256'(3'b100));
    checkOutput("timeout_beats", 256'(beat_count - b0), 256'(0));
    m_state_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] init index 5, no context");
    wr0 = state_wr_count;
    applyStimulus(8, 0, 5);
    checkOutput("timeout_cleared", 256'(o_timeout), 256'(0));
    waitStart();
    checkInit("B", 64, 1, 2, wr0);
    runToComplete(10);
    readBack(64, -1, 10);
    @(posedge clk); #1;

    $display("[TB] init index 261 wraps to 5");
    wr0 = state_wr_count;
    applyStimulus(8, 3, 261);
    loadContext(3);
    waitStart();
    checkInit("C", 64, 1, 2, wr0);
    runToComplete(2);
    readBack(64, -1, 2);
    @(posedge clk); #1;

    $display("[TB] reset during state init row 20");
    applyStimulus(8, 4, 0);
    loadContext(4);
    g = 0;
    @(negedge clk);
    while (!(o_qea_state_wea != 4'd0 && o_qea_state_addra == 16'd20) && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("reached_row20", 256'(o_qea_state_addra), 256'(20));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_flags", 256'({o_busy, o_done, o_timeout, m_state_valid, s_ctx_ready, o_qea_start, o_qea_ctx_en}), 256'(0));
    checkOutput("arst_ram_strobes", 256'({o_qea_state_ena, o_qea_state_wea}), 256'(0));
    checkOutput("arst_addr_dina", 256'(o_qea_state_addra) | o_qea_state_dina, 256'(0));
    checkOutput("arst_regs", 256'({o_cycle_count, o_qea_qbit_num}) | m_state_data, 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wr0 = state_wr_count;
    applyStimulus(3, 5, 7);
    loadContext(5);
    waitStart();
    checkInit("R", 2, 1, 0, wr0);
    runToComplete(5);
    readBack(2, -1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/qea_host_sequencer.md
QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 SHALL have parameters: PE_NUM 4, lanes per state word; PE_NUM_WIDTH 2, log2(PE_NUM); DATA_WIDTH 32, real/imag width; NUM_FRAC_BIT 30, fixed-point fraction bits; MAX_QBIT_WIDTH 6, qubit-count width; STATE_ADDR_WIDTH 16; GATE_CONTEXT_ADDR_WIDTH 16; RD_LATENCY 1, state RAM read latency in cycles; CYC_CNT_WIDTH 32; TIMEOUT_CYCLES 2**20, 0 = disabled.
REQ-002 SHALL use one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-003 SHALL have host ports: i_go in 1, sequence start pulse; i_qbit_num in MAX_QBIT_WIDTH, qubit count; i_ins_num in GATE_CONTEXT_ADDR_WIDTH, context words to load; i_init_idx in STATE_ADDR_WIDTH+PE_NUM_WIDTH, initial basis index.
REQ-004 SHALL have context stream ports: s_ctx_valid in 1; s_ctx_ready out 1; s_ctx_data in 2*DATA_WIDTH.
REQ-005 SHALL have readback ports: m_state_valid out 1; m_state_ready in 1; m_state_data out PE_NUM*2*DATA_WIDTH; m_state_last out 1.
REQ-006 SHALL have status ports: o_busy out 1; o_done out 1, one-cycle pulse; o_timeout out 1, sticky until next i_go; o_cycle_count out CYC_CNT_WIDTH.
REQ-007 SHALL have emulator ports: o_qea_start out 1; o_qea_qbit_num out MAX_QBIT_WIDTH; o_qea_ctx_en, o_qea_ctx_wea out 1; o_qea_ctx_addr out GATE_CONTEXT_ADDR_WIDTH; o_qea_ctx_data out 2*DATA_WIDTH; o_qea_state_ena, o_qea_state_wea out PE_NUM; o_qea_state_addra out STATE_ADDR_WIDTH; o_qea_state_dina out PE_NUM*2*DATA_WIDTH; i_qea_complete in 1; i_qea_state_dout in PE_NUM*2*DATA_WIDTH.

Function
REQ-008 SHALL implement states IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_HOLD, DONE.
REQ-009 IDLE: i_go=1 latches i_qbit_num, i_ins_num, i_init_idx; next state LOAD_CTX, or INIT_STATE if i_ins_num=0; i_go ignored when not IDLE.
REQ-010 LOAD_CTX: s_ctx_ready=1; each valid&ready cycle drives ctx_en=wea=1, data=s_ctx_data, addr=0,1,2,... contiguous; after the i_ins_num-th word, go to INIT_STATE.
REQ-011 INIT_STATE: ROWS = 2**(qbit_num-PE_NUM_WIDTH), ROWS = 1 if qbit_num<=PE_NUM_WIDTH; one row per cycle, addr 0..ROWS-1, ena=wea=all ones.
REQ-012 Row init: lane j occupies dina[j*2*DATA_WIDTH +: 2*DATA_WIDTH], real part in the upper DATA_WIDTH bits; basis index k maps to row k>>PE_NUM_WIDTH, lane PE_NUM-1-(k mod PE_NUM); that lane's real part = 2**NUM_FRAC_BIT, imag = 0; all other lanes zero.
REQ-013 i_init_idx >= 2**qbit_num SHALL wrap modulo 2**qbit_num.
REQ-014 START: o_qea_start=1 for exactly one cycle; then RUN.
REQ-015 o_cycle_count SHALL clear on START and increment every RUN cycle; it freezes on the RUN cycle where i_qea_complete=1, that cycle included.
REQ-016 RUN: i_qea_complete=1 -> RD_ISSUE; if TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES without completion, set o_timeout, skip readback, go DONE.
REQ-017 Readback per row: RD_ISSUE drives ena=all ones, wea=0, addr=row for one cycle; RD_WAIT waits RD_LATENCY cycles; dout is captured into m_state_data; RD_HOLD holds m_state_valid=1 with stable data until m_state_ready.
REQ-018 m_state_last=1 SHALL accompany the row ROWS-1 beat; its handshake leads to DONE; other handshakes lead to RD_ISSUE for the next row.
REQ-019 DONE: o_done=1 for one cycle; then IDLE.
REQ-020 o_busy=1 in every state except IDLE.
REQ-021 o_qea_qbit_num SHALL hold the latched qubit count whenever busy.
REQ-022 All emulator enable/write strobes SHALL be 0 outside the states that drive them.

Reset
REQ-023 rst_n=0 SHALL force IDLE at any time, including mid-sequence, and clear every output, counter and latched register to 0.
REQ-024 After reset release, the first i_go SHALL start a full sequence with no residual state.

Verification
REQ-025 qbit 8, ins 209 words streamed with no gaps, init_idx 0 -> ctx addr 0..208 written once each; 64 state rows written; row 0 dina = 0x40000000_00000000 in top lane, all else 0.
REQ-026 init_idx 5, qbit 8 -> only row 1, lane 2 real part = 0x40000000; init_idx 261 -> same result (wrap).
REQ-027 complete asserted 37 cycles after start -> o_cycle_count=37; 64 readback beats; last on beat 64; o_done one cycle after the final handshake.
REQ-028 m_state_ready held low 10 cycles on beat 3 -> data stable and valid held; no RAM read issued meanwhile.
REQ-029 TIMEOUT_CYCLES=100, complete never asserted -> o_timeout=1 after 100 RUN cycles, zero readback beats, o_done pulse.
REQ-030 rst_n low during INIT_STATE row 20 -> all outputs 0 asynchronously; next i_go reloads from ctx addr 0.
